word_reducer_pipelined: RTL and testbench

Pipelined, parametrised word-wide reducer: combines WORD_COUNT input words bit-wise into one WORD_WIDTH result. The operation (OR, AND, XOR) is selected per transaction, and a per-word mask excludes words from the result. Transactions enter and leave through valid/ready handshakes, and the pipeline fully supports backpressure. It replaces the purely combinational OR-reducer wherever word count or width would otherwise create a long timing path.

---
 rtl/word_reducer_pkg.sv | 50 +++++
 rtl/word_reducer_pipelined_if.sv | 26 ++
 rtl/word_reducer_stage.sv | 81 ++++++++
 rtl/word_reducer_pipelined.sv | 81 ++++++++
 tb/tb_word_reducer_pipelined.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_reducer_pkg.sv
// Shared definitions for the pipelined word reducer: op encodings,
// op normalisation/identity helpers and pipeline geometry functions.
package word_reducer_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  // Reserved encoding 11 is folded onto OR so downstream only sees legal ops.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    logic [1:0] res;
    res = (op == 2'b11) ? OP_OR : op;
    return res;
  endfunction

  // Identity for an op as a fill bit; callers replicate it across the word
  // (all-ones for AND, all-zeros for OR/XOR).
  function automatic logic op_identity(input logic [1:0] op);
    logic res;
    res = (op == OP_AND);
    return res;
  endfunction

  // Number of partial words present after `level` rounds of fan-in.
  function automatic int level_count(input int count, input int fanin, input int level);
    int c;
    c = count;
    for (int i = 0; i < 32; i++) begin
      if (i < level) c = (c + fanin - 1) / fanin;
    end
    return c;
  endfunction

  // Pipeline depth: ceil(log_fanin(count)), never less than one stage.
  function automatic int calc_stages(input int count, input int fanin);
    int s;
    int span;
    s    = 0;
    span = 1;
    for (int i = 0; i < 32; i++) begin
      if (span < count) begin
        span = span * fanin;
        s++;
      end
    end
    if (s == 0) s = 1;
    return s;
  endfunction

endpackage

// File: rtl/word_reducer_pipelined_if.sv
// Transaction-level handshake bundle between a producer/consumer and the
// pipelined word reducer.
interface word_reducer_pipelined_if #(
  parameter int WORD_WIDTH = 32,
  parameter int WORD_COUNT = 8
);
  logic [WORD_WIDTH*WORD_COUNT-1:0] in_words;
  logic [WORD_COUNT-1:0]            in_mask;
  logic [1:0]                       in_op;
  logic                             in_valid;
  logic                             in_ready;
  logic [WORD_WIDTH-1:0]            out_word;
  logic [1:0]                       out_op;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output in_words, in_mask, in_op, in_valid, out_ready,
    input  in_ready, out_word, out_op, out_valid
  );

  modport slave (
    input  in_words, in_mask, in_op, in_valid, out_ready,
    output in_ready, out_word, out_op, out_valid
  );
endinterface

// File: rtl/word_reducer_stage.sv
// One reducer pipeline stage: folds each group of STAGE_FANIN words with the
// transaction op (incomplete last group padded with the op identity) and
// registers the partials, op and valid flag when the stage is allowed to load.
module word_reducer_stage
  import word_reducer_pkg::*;
#(
  parameter int  WORD_WIDTH  = 32,
  parameter int  IN_COUNT    = 8,
  parameter int  STAGE_FANIN = 4,
  localparam int OUT_COUNT   = (IN_COUNT + STAGE_FANIN - 1) / STAGE_FANIN
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            load,
  input  logic                            in_valid,
  input  logic [1:0]                      in_op,
  input  logic [WORD_WIDTH*IN_COUNT-1:0]  in_words,
  output logic                            out_valid,
  output logic [1:0]                      out_op,
  output logic [WORD_WIDTH*OUT_COUNT-1:0] out_words
);

  localparam int PAD_COUNT = OUT_COUNT * STAGE_FANIN;

  function automatic logic [WORD_WIDTH-1:0] combine(
    input logic [1:0]            op,
    input logic [WORD_WIDTH-1:0] a,
    input logic [WORD_WIDTH-1:0] b
  );
    logic [WORD_WIDTH-1:0] res;
    case (op)
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      default: res = a | b;
    endcase
    return res;
  endfunction

  logic [WORD_WIDTH*PAD_COUNT-1:0] padded;
  logic [WORD_WIDTH*OUT_COUNT-1:0] comb_words;

  genvar gi, gg, gj;
  for (gi = 0; gi < PAD_COUNT; gi++) begin : g_pad
    if (gi < IN_COUNT) begin : g_real
      assign padded[gi*WORD_WIDTH +: WORD_WIDTH] = in_words[gi*WORD_WIDTH +: WORD_WIDTH];
    end else begin : g_fill
      assign padded[gi*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{op_identity(in_op)}};
    end
  end

  // Each fold step owns its own accumulator so the chain is a plain tree.
  for (gg = 0; gg < OUT_COUNT; gg++) begin : g_grp
    for (gj = 0; gj < STAGE_FANIN; gj++) begin : g_step
      logic [WORD_WIDTH-1:0] acc;
      if (gj == 0) begin : g_first
        assign acc = padded[(gg*STAGE_FANIN)*WORD_WIDTH +: WORD_WIDTH];
      end else begin : g_next
        assign acc = combine(in_op, g_step[gj-1].acc,
                             padded[(gg*STAGE_FANIN+gj)*WORD_WIDTH +: WORD_WIDTH]);
      end
    end
    assign comb_words[gg*WORD_WIDTH +: WORD_WIDTH] = g_step[STAGE_FANIN-1].acc;
  end

  // Stage register: when loading, take the upstream offer (or empty out);
  // payload only changes when something real arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= OP_OR;
      out_words <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_op    <= in_op;
        out_words <= comb_words;
      end
    end
  end

endmodule

// File: rtl/word_reducer_pipelined.sv
// Pipelined word reducer top: masks input words to the op identity, then
// reduces them through STAGES fan-in stages with per-stage valid/ready flow
// control so empty stages absorb work even while the output is stalled.
module word_reducer_pipelined
  import word_reducer_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int WORD_COUNT  = 8,
  parameter int STAGE_FANIN = 4
) (
  input logic                     clock,
  input logic                     reset,
  word_reducer_pipelined_if.slave bus
);

  localparam int STAGES = calc_stages(WORD_COUNT, STAGE_FANIN);

  logic [1:0]                       op_p0;
  logic [WORD_WIDTH*WORD_COUNT-1:0] masked_p0;
  logic [STAGES-1:0]                vld_p;
  logic [STAGES-1:0]                ld;

  assign op_p0 = norm_op(bus.in_op);

  genvar gi, gk;
  for (gi = 0; gi < WORD_COUNT; gi++) begin : g_mask
    assign masked_p0[gi*WORD_WIDTH +: WORD_WIDTH] = bus.in_mask[gi]
      ? bus.in_words[gi*WORD_WIDTH +: WORD_WIDTH]
      : {WORD_WIDTH{op_identity(op_p0)}};
  end

  // A stage may load if the output drains or any stage at or below it is
  // empty; written flat so bubbles collapse without a chained ready vector.
  for (gk = 0; gk < STAGES; gk++) begin : g_load
    assign ld[gk] = bus.out_ready | ~(&vld_p[STAGES-1:gk]);
  end

  assign bus.in_ready = ld[0];

  for (gk = 0; gk < STAGES; gk++) begin : g_stage
    localparam int IN_CNT  = level_count(WORD_COUNT, STAGE_FANIN, gk);
    localparam int OUT_CNT = level_count(WORD_COUNT, STAGE_FANIN, gk + 1);

    logic [WORD_WIDTH*IN_CNT-1:0]  words_in;
    logic [1:0]                    op_in;
    logic                          vld_in;
    logic [WORD_WIDTH*OUT_CNT-1:0] words_q;
    logic [1:0]                    op_q;

    if (gk == 0) begin : g_head
      assign words_in = masked_p0;
      assign op_in    = op_p0;
      assign vld_in   = bus.in_valid;
    end else begin : g_body
      assign words_in = g_stage[gk-1].words_q;
      assign op_in    = g_stage[gk-1].op_q;
      assign vld_in   = vld_p[gk-1];
    end

    word_reducer_stage #(
      .WORD_WIDTH  (WORD_WIDTH),
      .IN_COUNT    (IN_CNT),
      .STAGE_FANIN (STAGE_FANIN)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .load      (ld[gk]),
      .in_valid  (vld_in),
      .in_op     (op_in),
      .in_words  (words_in),
      .out_valid (vld_p[gk]),
      .out_op    (op_q),
      .out_words (words_q)
    );
  end

  assign bus.out_word  = g_stage[STAGES-1].words_q;
  assign bus.out_op    = g_stage[STAGES-1].op_q;
  assign bus.out_valid = vld_p[STAGES-1];

endmodule

// File: tb/tb_word_reducer_pipelined.sv
// Directed bench for word_reducer_pipelined: three configurations
// (8 words, 5 words with padding, 1 word) sharing clock and reset.
module tb_word_reducer_pipelined;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  word_reducer_pipelined_if #(.WORD_WIDTH(8), .WORD_COUNT(8)) bus_a ();
  word_reducer_pipelined_if #(.WORD_WIDTH(8), .WORD_COUNT(5)) bus_b ();
  word_reducer_pipelined_if #(.WORD_WIDTH(8), .WORD_COUNT(1)) bus_c ();

  word_reducer_pipelined #(.WORD_WIDTH(8), .WORD_COUNT(8), .STAGE_FANIN(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  word_reducer_pipelined #(.WORD_WIDTH(8), .WORD_COUNT(5), .STAGE_FANIN(4)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));
  word_reducer_pipelined #(.WORD_WIDTH(8), .WORD_COUNT(1), .STAGE_FANIN(4)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c));

  localparam logic [63:0] ONEHOT_WORDS = 64'h8040201008040201;

  typedef struct packed {
    logic [7:0] w;
    logic [1:0] o;
  } res_t;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_word(input logic [63:0] w, input logic [7:0] m,
                                            input logic [1:0] op);
    logic [7:0] acc;
    logic [7:0] b;
    acc = (op == 2'b01) ? 8'hFF : 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        b = w[8*i +: 8];
        case (op)
          2'b01:   acc = acc & b;
          2'b10:   acc = acc ^ b;
          default: acc = acc | b;
        endcase
      end
    end
    return acc;
  endfunction

  task automatic send_a(input logic [63:0] w, input logic [7:0] m, input logic [1:0] op,
                        output logic [7:0] ow, output logic [1:0] oo, output int lat);
    bus_a.in_words = w; bus_a.in_mask = m; bus_a.in_op = op;
    bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    lat = 0; ow = '0; oo = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      bus_a.in_valid = 1'b0;
      lat++;
      if (bus_a.out_valid) begin
        ow = bus_a.out_word; oo = bus_a.out_op;
        break;
      end
    end
  endtask

  task automatic send_b(input logic [39:0] w, input logic [4:0] m, input logic [1:0] op,
                        output logic [7:0] ow, output int lat);
    bus_b.in_words = w; bus_b.in_mask = m; bus_b.in_op = op;
    bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
    lat = 0; ow = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      bus_b.in_valid = 1'b0;
      lat++;
      if (bus_b.out_valid) begin
        ow = bus_b.out_word;
        break;
      end
    end
  endtask

  task automatic send_c(input logic [7:0] w, input logic m, input logic [1:0] op,
                        output logic [7:0] ow, output int lat);
    bus_c.in_words = w; bus_c.in_mask = m; bus_c.in_op = op;
    bus_c.in_valid = 1'b1; bus_c.out_ready = 1'b1;
    lat = 0; ow = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      bus_c.in_valid = 1'b0;
      lat++;
      if (bus_c.out_valid) begin
        ow = bus_c.out_word;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.in_words = '0; bus_a.in_mask = '0; bus_a.in_op = '0; bus_a.in_valid = 0; bus_a.out_ready = 1;
    bus_b.in_words = '0; bus_b.in_mask = '0; bus_b.in_op = '0; bus_b.in_valid = 0; bus_b.out_ready = 1;
    bus_c.in_words = '0; bus_c.in_mask = '0; bus_c.in_op = '0; bus_c.in_valid = 0; bus_c.out_ready = 1;
    #12;
    n_vec++;
    if (bus_a.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", bus_a.out_valid);
    end
    n_vec++;
    if (bus_a.out_word !== 8'h00) begin
      n_err++; $display("FAIL reset_word: got %h expected 00", bus_a.out_word);
    end
    n_vec++;
    if (bus_a.out_op !== 2'b00) begin
      n_err++; $display("FAIL reset_op: got %b expected 00", bus_a.out_op);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_vec++;
    if (bus_a.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus_a.in_ready);
    end
  endtask

  task automatic test_or_latency();
    logic [7:0] ow; logic [1:0] oo; int lat;
    send_a(ONEHOT_WORDS, 8'hFF, 2'b00, ow, oo, lat);
    n_vec++;
    if (ow !== 8'hFF) begin n_err++; $display("FAIL or_all: got %h expected ff", ow); end
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL or_latency: got %0d expected 2", lat); end
    n_vec++;
    if (oo !== 2'b00) begin n_err++; $display("FAIL or_op: got %b expected 00", oo); end
  endtask

  task automatic test_ops_masks();
    logic [7:0] ow; logic [1:0] oo; int lat;
    send_a(ONEHOT_WORDS, 8'h01, 2'b01, ow, oo, lat);
    n_vec++;
    if (ow !== 8'h01 || oo !== 2'b01) begin
      n_err++; $display("FAIL and_mask01: got %h/%b expected 01/01", ow, oo);
    end
    send_a(ONEHOT_WORDS, 8'h00, 2'b01, ow, oo, lat);
    n_vec++;
    if (ow !== 8'hFF) begin n_err++; $display("FAIL and_mask00: got %h expected ff", ow); end
    send_a(ONEHOT_WORDS, 8'h00, 2'b10, ow, oo, lat);
    n_vec++;
    if (ow !== 8'h00 || oo !== 2'b10) begin
      n_err++; $display("FAIL xor_mask00: got %h/%b expected 00/10", ow, oo);
    end
    send_a(ONEHOT_WORDS, 8'hFF, 2'b01, ow, oo, lat);
    n_vec++;
    if (ow !== 8'h00) begin n_err++; $display("FAIL and_all: got %h expected 00", ow); end
    send_a(ONEHOT_WORDS, 8'hA5, 2'b10, ow, oo, lat);
    n_vec++;
    if (ow !== 8'hA5) begin n_err++; $display("FAIL xor_a5: got %h expected a5", ow); end
    send_a(ONEHOT_WORDS, 8'h3C, 2'b11, ow, oo, lat);
    n_vec++;
    if (ow !== 8'h3C || oo !== 2'b00) begin
      n_err++; $display("FAIL reserved_op: got %h/%b expected 3c/00", ow, oo);
    end
  endtask

  task automatic test_padding();
    logic [7:0] ow; int lat;
    send_b(40'h0101FFF00F, 5'h1F, 2'b10, ow, lat);
    n_vec++;
    if (ow !== 8'h00 || lat !== 2) begin
      n_err++; $display("FAIL pad_xor: got %h lat %0d expected 00 lat 2", ow, lat);
    end
    send_b(40'hFFFFFFFFFF, 5'h1F, 2'b01, ow, lat);
    n_vec++;
    if (ow !== 8'hFF) begin n_err++; $display("FAIL pad_and: got %h expected ff", ow); end
    send_b(40'h0101FFF00F, 5'h01, 2'b01, ow, lat);
    n_vec++;
    if (ow !== 8'h0F) begin n_err++; $display("FAIL pad_and_m01: got %h expected 0f", ow); end
    send_b(40'h0102040810, 5'h1E, 2'b00, ow, lat);
    n_vec++;
    if (ow !== 8'h0F) begin n_err++; $display("FAIL pad_or_m1e: got %h expected 0f", ow); end
  endtask

  task automatic test_single_word();
    logic [7:0] ow; int lat;
    send_c(8'h5A, 1'b1, 2'b00, ow, lat);
    n_vec++;
    if (ow !== 8'h5A || lat !== 1) begin
      n_err++; $display("FAIL single_or: got %h lat %0d expected 5a lat 1", ow, lat);
    end
    send_c(8'h5A, 1'b0, 2'b01, ow, lat);
    n_vec++;
    if (ow !== 8'hFF || lat !== 1) begin
      n_err++; $display("FAIL single_and_masked: got %h lat %0d expected ff lat 1", ow, lat);
    end
    send_c(8'h3C, 1'b1, 2'b10, ow, lat);
    n_vec++;
    if (ow !== 8'h3C) begin n_err++; $display("FAIL single_xor: got %h expected 3c", ow); end
  endtask

  task automatic test_backpressure();
    int accepts; logic rdy; logic stable;
    @(posedge clock); #1;
    bus_a.out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_words = ONEHOT_WORDS;
      bus_a.in_mask  = 8'(8'h01 << accepts);
      bus_a.in_op    = 2'b00;
      bus_a.in_valid = 1'b1;
      #1; rdy = bus_a.in_ready;
      @(posedge clock); #1;
      if (rdy) accepts++;
    end
    bus_a.in_valid = 1'b0;
    n_vec++;
    if (accepts !== 2) begin n_err++; $display("FAIL bp_accepts: got %0d expected 2", accepts); end
    n_vec++;
    if (bus_a.in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_in_ready: got %b expected 0", bus_a.in_ready);
    end
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus_a.out_valid !== 1'b1 || bus_a.out_word !== 8'h01) stable = 1'b0;
      @(posedge clock); #1;
    end
    n_vec++;
    if (!stable) begin
      n_err++; $display("FAIL bp_hold: got %b/%h expected 1/01", bus_a.out_valid, bus_a.out_word);
    end
    bus_a.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus_a.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready: got %b expected 1", bus_a.in_ready);
    end
    @(posedge clock); #1;
    n_vec++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_word !== 8'h02) begin
      n_err++; $display("FAIL bp_second: got %b/%h expected 1/02", bus_a.out_valid, bus_a.out_word);
    end
    @(posedge clock); #1;
    n_vec++;
    if (bus_a.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drained: got %b expected 0", bus_a.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    res_t exp_q[$];
    res_t e;
    int sent, got;
    logic acc, hold;
    logic [7:0] hw; logic [1:0] ho;
    logic quiet;
    sent = 0; got = 0;
    bus_a.in_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      if (!bus_a.in_valid && sent < 20) begin
        bus_a.in_words = {$urandom, $urandom};
        bus_a.in_mask  = 8'($urandom_range(0, 255));
        bus_a.in_op    = 2'($urandom_range(0, 3));
        bus_a.in_valid = 1'b1;
      end
      bus_a.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus_a.in_valid && bus_a.in_ready;
      if (bus_a.out_valid && bus_a.out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra: got %h with nothing outstanding", bus_a.out_word);
        end else begin
          e = exp_q.pop_front();
          if (bus_a.out_word !== e.w || bus_a.out_op !== e.o) begin
            n_err++;
            $display("FAIL stream_result #%0d: got %h/%b expected %h/%b",
                     got, bus_a.out_word, bus_a.out_op, e.w, e.o);
          end
        end
        got++;
      end
      hold = bus_a.out_valid && !bus_a.out_ready;
      hw = bus_a.out_word; ho = bus_a.out_op;
      @(posedge clock); #1;
      if (hold) begin
        n_vec++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_word !== hw || bus_a.out_op !== ho) begin
          n_err++;
          $display("FAIL stall_stable: got %b/%h/%b expected 1/%h/%b",
                   bus_a.out_valid, bus_a.out_word, bus_a.out_op, hw, ho);
        end
      end
      if (acc) begin
        e.w = model_word(bus_a.in_words, bus_a.in_mask, bus_a.in_op);
        e.o = (bus_a.in_op == 2'b11) ? 2'b00 : bus_a.in_op;
        exp_q.push_back(e);
        sent++;
        bus_a.in_valid = 1'b0;
      end
    end
    bus_a.in_valid = 1'b0;
    n_vec++;
    if (sent !== 20 || got !== 20 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL stream_count: sent %0d got %0d left %0d expected 20/20/0", sent, got, exp_q.size());
    end
    bus_a.out_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (bus_a.out_valid !== 1'b0) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin n_err++; $display("FAIL stream_duplicate: got extra out_valid expected none"); end
  endtask

  task automatic test_reset_midflight();
    logic quiet;
    bus_a.out_ready = 1'b0;
    bus_a.in_words = ONEHOT_WORDS; bus_a.in_mask = 8'hFF; bus_a.in_op = 2'b00;
    bus_a.in_valid = 1'b1;
    @(posedge clock); #1;
    bus_a.in_mask = 8'h0F;
    @(posedge clock); #1;
    bus_a.in_valid = 1'b0;
    n_vec++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_word !== 8'hFF) begin
      n_err++; $display("FAIL flight_before: got %b/%h expected 1/ff", bus_a.out_valid, bus_a.out_word);
    end
    #1; reset = 1'b1; #1;
    n_vec++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_word !== 8'h00) begin
      n_err++; $display("FAIL async_reset: got %b/%h expected 0/00", bus_a.out_valid, bus_a.out_word);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    bus_a.out_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (bus_a.out_valid !== 1'b0) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin n_err++; $display("FAIL stale_after_reset: got out_valid 1 expected 0"); end
    n_vec++;
    if (bus_a.in_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b expected 1", bus_a.in_ready);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_or_latency();
    test_ops_masks();
    test_padding();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
